// File: rtl/hsv_core_flush_ctrl.sv
// Flush coordinator: fixed-priority arbitration of flush requesters, global
// flush_req with raise/fall ack handshake, ack pending vector and sticky timeout.
module hsv_core_flush_ctrl #(
    parameter int unsigned NUM_SRCS       = 4,
    parameter int unsigned NUM_ACKS       = 9,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                   clk_core,
    input  logic                   rst_core_n,
    input  logic [NUM_SRCS-1:0]    src_valid,
    input  logic [NUM_SRCS*32-1:0] src_target,
    output logic [NUM_SRCS-1:0]    src_ready,
    input  logic [NUM_ACKS-1:0]    ack_mask,
    input  logic [NUM_ACKS-1:0]    flush_ack,
    output logic                   flush_req,
    output logic [31:0]            flush_target,
    output logic                   flush_done,
    output logic                   flush_busy,
    output logic [NUM_ACKS-1:0]    ack_pending,
    output logic                   flush_timeout,
    input  logic                   timeout_clear
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RAISE = 2'd1;
    localparam logic [1:0] ST_FALL  = 2'd2;

    logic [1:0]          state_q, state_d;
    logic                flush_req_q, flush_req_d;
    logic [31:0]         target_q, target_d;
    logic                done_q, done_d;
    logic                timeout_q, timeout_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic                grant_found;
    logic [NUM_SRCS-1:0] grant_oh;
    logic [31:0]         grant_target;
    logic                raise_ok;
    logic                fall_ok;
    logic                busy;

    // Lowest index wins; the first hit blocks every later source.
    always_comb begin
        grant_found  = 1'b0;
        grant_oh     = '0;
        grant_target = '0;
        for (int unsigned i = 0; i < NUM_SRCS; i++) begin
            if (src_valid[i] && !grant_found) begin
                grant_found  = 1'b1;
                grant_oh     = NUM_SRCS'(1) << i;
                grant_target = 32'(src_target >> (32 * i));
            end
        end
    end

    assign raise_ok = &(flush_ack | ack_mask);
    assign fall_ok  = ~|(flush_ack & ~ack_mask);
    assign busy     = (state_q != ST_IDLE);

    always_comb begin
        state_d     = state_q;
        flush_req_d = flush_req_q;
        target_d    = target_q;
        done_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant_found) begin
                    state_d     = ST_RAISE;
                    flush_req_d = 1'b1;
                    target_d    = grant_target;
                end
            end
            ST_RAISE: begin
                if (raise_ok) begin
                    state_d     = ST_FALL;
                    flush_req_d = 1'b0;
                    done_d      = 1'b1;
                end
            end
            ST_FALL: begin
                if (fall_ok) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                flush_req_d = 1'b0;
            end
        endcase
    end

    // Phase timer restarts on every state change and saturates at the limit.
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (busy && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_comb begin
        timeout_d = timeout_q;
        if ((TIMEOUT_CYCLES != 0) && busy && (cnt_q == CNT_MAX)) begin
            timeout_d = 1'b1;
        end else if (timeout_clear) begin
            timeout_d = 1'b0;
        end
    end

    always_ff @(posedge clk_core or negedge rst_core_n) begin
        if (!rst_core_n) begin
            state_q     <= ST_IDLE;
            flush_req_q <= 1'b0;
            target_q    <= '0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            flush_req_q <= flush_req_d;
            target_q    <= target_d;
            done_q      <= done_d;
            timeout_q   <= timeout_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        ack_pending = '0;
        case (state_q)
            ST_RAISE: ack_pending = ~flush_ack & ~ack_mask;
            ST_FALL:  ack_pending = flush_ack & ~ack_mask;
            default:  ack_pending = '0;
        endcase
    end

    assign src_ready     = (state_q == ST_IDLE) ? grant_oh : '0;
    assign flush_req     = flush_req_q;
    assign flush_target  = target_q;
    assign flush_done    = done_q;
    assign flush_busy    = busy;
    assign flush_timeout = timeout_q;

endmodule

// File: tb/tb_hsv_core_flush_ctrl.sv
// Scoreboard bench for hsv_core_flush_ctrl: random request bursts against a
// transaction-level timing model, plus directed timeout and reset scenarios.
module tb_hsv_core_flush_ctrl;

    localparam int unsigned NS = 4;
    localparam int unsigned NA = 9;
    localparam int unsigned TO = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NS-1:0]     src_valid = '0;
    logic [NS*32-1:0]  src_target = '0;
    logic [NS-1:0]     src_ready;
    logic [NA-1:0]     ack_mask = '0;
    logic [NA-1:0]     flush_ack = '0;
    logic              flush_req;
    logic [31:0]       flush_target;
    logic              flush_done;
    logic              flush_busy;
    logic [NA-1:0]     ack_pending;
    logic              flush_timeout;
    logic              timeout_clear = 1'b0;

    always #5 clk = ~clk;

    hsv_core_flush_ctrl #(
        .NUM_SRCS(NS),
        .NUM_ACKS(NA),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_core(clk),
        .rst_core_n(rst_n),
        .src_valid(src_valid),
        .src_target(src_target),
        .src_ready(src_ready),
        .ack_mask(ack_mask),
        .flush_ack(flush_ack),
        .flush_req(flush_req),
        .flush_target(flush_target),
        .flush_done(flush_done),
        .flush_busy(flush_busy),
        .ack_pending(ack_pending),
        .flush_timeout(flush_timeout),
        .timeout_clear(timeout_clear)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Stage responder: each unmasked ack echoes flush_req delayed by its lag;
    // masked channels carry random noise that the DUT must ignore.
    bit          resp_en = 1'b0;
    logic [NA-1:0] dir_ack = '0;
    logic [7:0]  hist = '0;
    int unsigned lag [NA];

    always @(posedge clk) begin
        #2;
        hist = {hist[6:0], flush_req};
        if (resp_en) begin
            for (int ch = 0; ch < NA; ch++)
                flush_ack[ch] = ack_mask[ch] ? 1'($urandom % 2) : hist[lag[ch]];
        end else begin
            flush_ack = dir_ack;
        end
    end

    typedef struct packed {
        logic [31:0] tgt;
        logic [7:0]  idx;
        logic [7:0]  maxl;
    } item_t;

    item_t sbq[$];

    // Monitor: expected timeline per grant g with slowest unmasked lag L:
    // RAISE over (g, g+2+L), flush_done at g+2+L, FALL until g+3+2L.
    bit          mon_en = 1'b0;
    bit          active = 1'b0;
    int          g_cyc, exp_done, exp_idle;
    logic [31:0] cur_tgt;
    bit          raise_ph, fall_ph, busy_ph;
    logic [NA-1:0] exp_pend;
    logic [NS-1:0] exp_oh;
    item_t       it;

    always @(negedge clk) begin
        if (!mon_en) begin
            active = 1'b0;
        end else begin
            raise_ph = active && (cyc > g_cyc) && (cyc < exp_done);
            fall_ph  = active && (cyc >= exp_done) && (cyc < exp_idle);
            busy_ph  = raise_ph || fall_ph;
            check("flush_req", 64'(flush_req), 64'(raise_ph));
            check("flush_done", 64'(flush_done), 64'(active && (cyc == exp_done)));
            check("flush_busy", 64'(flush_busy), 64'(busy_ph));
            if (active && (cyc > g_cyc)) check("flush_target", 64'(flush_target), 64'(cur_tgt));
            exp_pend = raise_ph ? (~flush_ack & ~ack_mask) : fall_ph ? (flush_ack & ~ack_mask) : '0;
            check("ack_pending", 64'(ack_pending), 64'(exp_pend));
            if (busy_ph) begin
                check("src_ready_busy", 64'(src_ready), 64'd0);
            end else if (src_valid != '0) begin
                check("grant_present", 64'(src_ready != '0), 64'd1);
                if (src_ready != '0) begin
                    if (sbq.size() == 0) begin
                        check("grant_unexpected", 64'(src_ready), 64'd0);
                    end else begin
                        it = sbq.pop_front();
                        exp_oh = '0;
                        exp_oh[it.idx[1:0]] = 1'b1;
                        check("grant_onehot", 64'(src_ready), 64'(exp_oh));
                        g_cyc    = cyc;
                        exp_done = cyc + 2 + int'(it.maxl);
                        exp_idle = cyc + 3 + 2 * int'(it.maxl);
                        cur_tgt  = it.tgt;
                        active   = 1'b1;
                    end
                end
            end
        end
    end

    task automatic run_bursts(input int n);
        logic [NS-1:0] vset, gr;
        logic [31:0]   tgt;
        int unsigned   maxl;
        int            budget;
        for (int b = 0; b < n; b++) begin
            case ($urandom % 4)
                0: ack_mask = 9'h1FF;
                1: ack_mask = 9'h001;
                2: ack_mask = NA'($urandom);
                default: ack_mask = '0;
            endcase
            maxl = 0;
            for (int ch = 0; ch < NA; ch++) begin
                lag[ch] = $urandom % 4;
                if (!ack_mask[ch] && lag[ch] > maxl) maxl = lag[ch];
            end
            vset = NS'($urandom);
            if (vset == '0) vset = NS'(1) << ($urandom % NS);
            for (int i = 0; i < NS; i++) begin
                tgt = $urandom;
                src_target[32*i +: 32] = tgt;
                if (vset[i]) sbq.push_back('{tgt: tgt, idx: 8'(i), maxl: 8'(maxl)});
            end
            src_valid = vset;
            budget = 0;
            while (src_valid != '0 && budget < 200) begin
                @(negedge clk);
                gr = src_ready;
                step();
                src_valid = src_valid & ~gr;
                budget++;
            end
            if (src_valid != '0) begin
                check("grant_wait_expired", 64'(src_valid), 64'd0);
                src_valid = '0;
                sbq.delete();
            end
            budget = 0;
            while (budget < 50) begin
                @(negedge clk);
                if (!flush_busy) break;
                budget++;
            end
            if (budget >= 50) check("idle_wait_expired", 64'(flush_busy), 64'd0);
            repeat (6) step();
        end
    endtask

    initial begin
        for (int ch = 0; ch < NA; ch++) lag[ch] = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_flush_req", 64'(flush_req), 64'd0);
        check("rst_flush_target", 64'(flush_target), 64'd0);
        check("rst_flush_done", 64'(flush_done), 64'd0);
        check("rst_flush_busy", 64'(flush_busy), 64'd0);
        check("rst_flush_timeout", 64'(flush_timeout), 64'd0);
        check("rst_ack_pending", 64'(ack_pending), 64'd0);
        check("rst_src_ready", 64'(src_ready), 64'd0);
        rst_n = 1'b1;
        resp_en = 1'b1;
        repeat (6) step();
        mon_en = 1'b1;
        run_bursts(30);

        // Timeout: ack[3] stuck low for more than TO cycles in RAISE.
        mon_en = 1'b0;
        resp_en = 1'b0;
        ack_mask = '0;
        dir_ack = '0;
        src_target[31:0] = 32'h0000_0ABC;
        src_valid = 4'b0001;
        @(negedge clk);
        check("to_grant", 64'(src_ready), 64'h1);
        step();
        src_valid = '0;
        dir_ack = 9'h1F7;
        @(negedge clk);
        check("to_pending", 64'(ack_pending), 64'h008);
        check("to_req", 64'(flush_req), 64'd1);
        check("to_early", 64'(flush_timeout), 64'd0);
        for (int k = 2; k <= 9; k++) begin
            step();
            @(negedge clk);
            check("to_early", 64'(flush_timeout), 64'd0);
        end
        step();
        dir_ack = '1;
        @(negedge clk);
        check("to_set", 64'(flush_timeout), 64'd1);
        check("to_still_raise", 64'(flush_req), 64'd1);
        step();
        @(negedge clk);
        check("to_done", 64'(flush_done), 64'd1);
        check("to_req_low", 64'(flush_req), 64'd0);
        check("to_target", 64'(flush_target), 64'hABC);
        step();
        dir_ack = '0;
        @(negedge clk);
        check("to_fall_busy", 64'(flush_busy), 64'd1);
        step();
        @(negedge clk);
        check("to_idle_busy", 64'(flush_busy), 64'd0);
        check("to_sticky", 64'(flush_timeout), 64'd1);
        step();
        timeout_clear = 1'b1;
        @(negedge clk);
        check("to_before_clear", 64'(flush_timeout), 64'd1);
        step();
        timeout_clear = 1'b0;
        @(negedge clk);
        check("to_cleared", 64'(flush_timeout), 64'd0);
        step();

        // Asynchronous reset while in RAISE.
        src_target[95:64] = 32'h0000_1000;
        src_valid = 4'b0100;
        @(negedge clk);
        check("rm_grant", 64'(src_ready), 64'h4);
        step();
        src_valid = '0;
        @(negedge clk);
        check("rm_req", 64'(flush_req), 64'd1);
        check("rm_target", 64'(flush_target), 64'h1000);
        step();
        rst_n = 1'b0;
        #1;
        check("rm_req_rst", 64'(flush_req), 64'd0);
        check("rm_busy_rst", 64'(flush_busy), 64'd0);
        check("rm_target_rst", 64'(flush_target), 64'd0);
        step();
        rst_n = 1'b1;
        resp_en = 1'b1;
        repeat (6) step();
        mon_en = 1'b1;
        run_bursts(10);

        check("sb_empty", 64'(sbq.size()), 64'd0);
        check("no_timeout", 64'(flush_timeout), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, failures so far %0d", n_fail);
        $fatal(1, "watchdog");
    end

endmodule
